// File: rtl/or4_selftest_pkg.sv
// Shared types and sizing helpers for the or4 built-in self-test block.
package or4_selftest_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Operand width used when the top is left at its default
  localparam int unsigned WIDTH_DEF = 4;

  // Drain counter must hold DUT_LAT-1 for latencies up to 4
  localparam int unsigned DRAIN_W = 3;

  // Vector index width: a and b concatenated
  function automatic int unsigned idx_w(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/or4_selftest_delay.sv
// Fixed-latency shift register aligning expected values with DUT responses.
module selftest_delay #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned DW    = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    // Zero latency: straight wire, clock and reset have no load here
    logic unused_c;
    assign unused_c = clk ^ rst;
    assign q_o      = d_i;
  end else begin : g_pipe
    logic [DW-1:0] pipe_q [DEPTH];
    logic [DW-1:0] pipe_d [DEPTH];

    // Next-stage values: stage 0 takes the input, others shift along
    always_comb begin
      pipe_d[0] = d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    // Pipeline registers, cleared so no stale valid survives a reset
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
      end else begin
        for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= pipe_d[i];
      end
    end

    assign q_o = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/or4_selftest.sv
// Built-in self-test for the or4 datapath: exhaustive a/b sweep, checks y
// against a|b, counts mismatches and records the first failing vector.
module or4_selftest
  import or4_selftest_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned DUT_LAT = 0,
  parameter int unsigned ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic [WIDTH-1:0] y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_y
);

  localparam int unsigned IDX_W = idx_w(WIDTH);
  localparam int unsigned DW    = 3 * WIDTH + 1;

  localparam logic [IDX_W-1:0]   IDX_LAST   = '1;
  localparam logic [ERR_W-1:0]   ERR_MAX    = '1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT =
    (DUT_LAT == 0) ? '0 : DRAIN_W'(DUT_LAT - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [WIDTH-1:0]   fail_a_q, fail_a_d, fail_b_q, fail_b_d, fail_y_q, fail_y_d;
  logic               first_q, first_d;

  logic [DW-1:0]      dly_in_c, dly_out_c;
  logic [WIDTH-1:0]   dly_a_c, dly_b_c, dly_exp_c;
  logic               dly_vld_c;
  logic               mismatch_c;

  // Expected value travels with its operands so it lines up with y_i
  assign dly_in_c = {a_q, b_q, a_q | b_q, (state_q == ST_RUN)};

  selftest_delay #(
    .DEPTH (DUT_LAT),
    .DW    (DW)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d_i (dly_in_c),
    .q_o (dly_out_c)
  );

  assign {dly_a_c, dly_b_c, dly_exp_c, dly_vld_c} = dly_out_c;
  assign mismatch_c = dly_vld_c && (y_i != dly_exp_c);

  // Next-state, vector generation and result bookkeeping
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    fail_y_d = fail_y_q;
    first_d  = first_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          idx_d    = '0;
          a_d      = '0;
          b_d      = '0;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          fail_y_d = '0;
          first_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (idx_q == IDX_LAST) begin
          if (DUT_LAT > 0) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_INIT;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
          a_d   = idx_d[IDX_W-1:WIDTH];
          b_d   = idx_d[WIDTH-1:0];
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Mismatch accounting; valid responses only exist during RUN/DRAIN
    if (mismatch_c) begin
      if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
      if (!first_q) begin
        first_d  = 1'b1;
        fail_a_d = dly_a_c;
        fail_b_d = dly_b_c;
        fail_y_d = y_i;
      end
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      drain_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      fail_y_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      fail_y_q <= fail_y_d;
      first_q  <= first_d;
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_y    = fail_y_q;

endmodule

// File: tb/tb_or4_selftest.sv
// Directed bench for or4_selftest: one zero-latency instance with selectable
// faulty DUT models and one DUT_LAT=2 instance fed by a two-stage OR model.
module tb_or4_selftest;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   mode;
  bit   sel;

  logic [3:0] a0, b0, y0, fa0, fb0, fy0;
  logic [3:0] a2, b2, y2, fa2, fb2, fy2;
  logic [7:0] err0, err2;
  logic       busy0, done0, pass0, busy2, done2, pass2;
  logic [3:0] r1_0, r2_0, r1_2, r2_2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Two-cycle registered OR models for each instance
  always_ff @(posedge clk) begin
    r1_0 <= a0 | b0;
    r2_0 <= r1_0;
    r1_2 <= a2 | b2;
    r2_2 <= r1_2;
  end

  // DUT model feeding the zero-latency instance
  always_comb begin
    case (mode)
      0:       y0 = a0 | b0;
      1:       y0 = (a0 | b0) & 4'hE;
      2:       y0 = 4'hF;
      3:       y0 = ~(a0 | b0);
      default: y0 = r2_0;
    endcase
  end
  assign y2 = r2_2;

  or4_selftest #(.WIDTH(4), .DUT_LAT(0), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .a_o(a0), .b_o(b0), .y_i(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_a(fa0), .fail_b(fb0), .fail_y(fy0)
  );

  or4_selftest #(.WIDTH(4), .DUT_LAT(2), .ERR_W(8)) u2 (
    .clk(clk), .rst(rst), .start(start), .a_o(a2), .b_o(b2), .y_i(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_a(fa2), .fail_b(fb2), .fail_y(fy2)
  );

  logic       busy_s, done_s, pass_s;
  logic [7:0] err_s;
  logic [3:0] fa_s, fb_s, fy_s;
  assign busy_s = sel ? busy2 : busy0;
  assign done_s = sel ? done2 : done0;
  assign pass_s = sel ? pass2 : pass0;
  assign err_s  = sel ? err2  : err0;
  assign fa_s   = sel ? fa2   : fa0;
  assign fb_s   = sel ? fb2   : fb0;
  assign fy_s   = sel ? fy2   : fy0;

  typedef struct {
    bit         sel;
    int         mode;
    int         busy;
    bit         pass;
    int         err;
    bit         detail;
    logic [3:0] fa, fb, fy;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Pulse start, count busy cycles of the selected instance until done
  task automatic run_once(output int busy_cnt, output bit to);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    busy_cnt = 0;
    to = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (done_s) begin
        to = 1'b0;
        break;
      end
      if (busy_s) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"},     32'(a0),    0);
    chk({tag, "_b"},     32'(b0),    0);
    chk({tag, "_busy"},  32'(busy0), 0);
    chk({tag, "_done"},  32'(done0), 0);
    chk({tag, "_pass"},  32'(pass0), 0);
    chk({tag, "_err"},   32'(err0),  0);
    chk({tag, "_fail"},  32'({fa0, fb0, fy0}), 0);
    chk({tag, "_busy2"}, 32'(busy2), 0);
  endtask

  initial begin
    int  bc;
    bit  to;

    //          sel mode busy pass err detail fa     fb     fy
    tbl[0] = '{0, 0, 256, 1, 0,   1, 4'h0, 4'h0, 4'h0};
    tbl[1] = '{0, 1, 256, 0, 192, 1, 4'h0, 4'h1, 4'h0};
    tbl[2] = '{0, 2, 256, 0, 175, 1, 4'h0, 4'h0, 4'hF};
    tbl[3] = '{0, 3, 256, 0, 255, 1, 4'h0, 4'h0, 4'hF};
    tbl[4] = '{0, 0, 256, 1, 0,   1, 4'h0, 4'h0, 4'h0};
    tbl[5] = '{1, 0, 258, 1, 0,   1, 4'h0, 4'h0, 4'h0};
    tbl[6] = '{0, 4, 256, 0, 0,   0, 4'h0, 4'h0, 4'h0};

    rst = 1'b1; start = 1'b0; mode = 0; sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    chk("idle_no_autostart", 32'(busy0), 0);

    for (int i = 0; i < 7; i++) begin
      mode = tbl[i].mode;
      sel  = tbl[i].sel;
      run_once(bc, to);
      chk($sformatf("v%0d_timeout", i), 32'(to), 0);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(tbl[i].busy));
      chk($sformatf("v%0d_done", i), 32'(done_s), 1);
      chk($sformatf("v%0d_pass", i), 32'(pass_s), 32'(tbl[i].pass));
      if (tbl[i].detail) begin
        chk($sformatf("v%0d_err", i), 32'(err_s), 32'(tbl[i].err));
        chk($sformatf("v%0d_fail_a", i), 32'(fa_s), 32'(tbl[i].fa));
        chk($sformatf("v%0d_fail_b", i), 32'(fb_s), 32'(tbl[i].fb));
        chk($sformatf("v%0d_fail_y", i), 32'(fy_s), 32'(tbl[i].fy));
      end
      repeat (5) @(negedge clk);
    end

    // Restart from DONE after a failing run: results clear, done drops
    sel = 1'b0; mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("restart_done_low", 32'(done0), 0);
    chk("restart_busy",     32'(busy0), 1);
    chk("restart_err_clr",  32'(err0),  0);
    chk("restart_fy_clr",   32'(fy0),   0);
    chk("restart_vec0",     32'({a0, b0}), 32'h00);
    @(negedge clk);
    chk("restart_vec1",     32'({a0, b0}), 32'h01);
    to = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (done0) begin to = 1'b0; break; end
      @(negedge clk);
    end
    chk("restart_timeout", 32'(to), 0);
    chk("restart_pass", 32'(pass0), 1);
    repeat (5) @(negedge clk);

    // Reset at RUN cycle 100 clears everything on the next edge
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (99) @(negedge clk);
    chk("midrun_busy_before_rst", 32'(busy0), 1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk_all_zero("midrun_rst");
    @(negedge clk);
    chk("post_rst_idle", 32'(busy0), 0);

    // Start pulse mid-RUN is ignored; run still takes 256 busy cycles
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    bc = 0; to = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      start = (c == 50);
      if (done0) begin to = 1'b0; break; end
      if (busy0) bc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore_start_timeout", 32'(to), 0);
    chk("ignore_start_busy", 32'(bc), 256);
    chk("ignore_start_pass", 32'(pass0), 1);
    chk("ignore_start_err", 32'(err0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
